// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer.
//   seq_state_t : sequencer FSM states (IDLE=0 .. GAP=4)
//   cmd_width   : width of a queued command word {rw, addr, data},
//                 with rw at the MSB, then addr, then data in the LSBs.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous FIFO with registered read data.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wr_data (ignored when full)
//   pop      : load rd_data from the head on the next edge (ignored when empty)
//   full, empty, count : occupancy, count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_cmd_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_seq.sv
// Command queue and sequencer in front of the SPI master.
// User logic pushes {rw, addr, data} commands (i_cmd_*, o_cmd_ready); the
// sequencer issues them one at a time as single-cycle o_spi_wr_evt /
// o_spi_rd_evt pulses with o_spi_addr / o_spi_wr_data held until the
// master reports i_spi_done_evt. Reads return o_rsp_valid/addr/data/err,
// writes pulse o_wr_done. A transaction without done within TIMEOUT_CYC
// cycles is aborted and latches o_timeout_flag. GAP_CYC idle cycles are
// inserted after every completion. o_busy covers queued or active work.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int unsigned AWIDTH      = 15,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'd20000
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rw,
  input  logic [AWIDTH-1:0] i_cmd_addr,
  input  logic [DWIDTH-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [AWIDTH-1:0] o_rsp_addr,
  output logic [DWIDTH-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_wr_done,
  output logic              o_busy,
  output logic              o_timeout_flag,
  output logic              o_spi_rd_evt,
  output logic              o_spi_wr_evt,
  output logic [AWIDTH-1:0] o_spi_addr,
  output logic [DWIDTH-1:0] o_spi_wr_data,
  input  logic              i_spi_rd_evt,
  input  logic [DWIDTH-1:0] i_spi_rd_data,
  input  logic              i_spi_done_evt
);

  localparam int unsigned CW   = cmd_width(AWIDTH, DWIDTH);
  localparam int unsigned GW   = $clog2(GAP_CYC + 1);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t        state;
  seq_state_t        state_next;

  logic [CW-1:0]     fifo_wr;
  logic [CW-1:0]     fifo_rd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNTW-1:0]   fifo_count;

  logic              ready_en;
  logic              rw_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wr_data_q;
  logic [DWIDTH-1:0] rd_cap;
  logic              got_rd;
  logic [31:0]       tmo_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              tmo_hit;
  logic              timeout_flag_q;

  // ready_en keeps o_cmd_ready low while in reset and rises one edge after
  // release; afterwards ready simply tracks the registered FIFO count.
  assign o_cmd_ready = ready_en && !fifo_full;
  assign fifo_push   = i_cmd_valid && o_cmd_ready;
  assign fifo_wr     = {i_cmd_rw, i_cmd_addr, i_cmd_data};

  spi_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (user_clk),
    .rst     (user_rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign o_busy         = (fifo_count != '0) || (state != IDLE);
  assign o_spi_addr     = addr_q;
  assign o_spi_wr_data  = wr_data_q;
  assign o_rsp_addr     = addr_q;
  assign o_timeout_flag = timeout_flag_q;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fifo_pop     = 1'b0;
    o_spi_wr_evt = 1'b0;
    o_spi_rd_evt = 1'b0;
    o_rsp_valid  = 1'b0;
    o_rsp_err    = 1'b0;
    o_rsp_data   = '0;
    o_wr_done    = 1'b0;
    tmo_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        o_spi_wr_evt = rw_q;
        o_spi_rd_evt = !rw_q;
        state_next   = WAIT;
      end
      WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (i_spi_done_evt) begin
          state_next = GAP;
          if (rw_q) begin
            o_wr_done = 1'b1;
          end else begin
            o_rsp_valid = 1'b1;
            // read data arriving with done has not been captured yet
            if (i_spi_rd_evt) begin
              o_rsp_data = i_spi_rd_data;
            end else if (got_rd) begin
              o_rsp_data = rd_cap;
            end
          end
        end else if (tmo_cnt == TIMEOUT_CYC - 32'd1) begin
          state_next = GAP;
          tmo_hit    = 1'b1;
          if (rw_q) begin
            o_wr_done = 1'b1;
          end else begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = 1'b1;
          end
        end
      end
      GAP: begin
        if ((32'(gap_cnt) + 32'd1) >= GAP_CYC) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ready_en       <= 1'b0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      wr_data_q      <= '0;
      rd_cap         <= '0;
      got_rd         <= 1'b0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (state == LOAD) begin
        rw_q      <= fifo_rd[CW-1];
        addr_q    <= fifo_rd[CW-2 -: AWIDTH];
        wr_data_q <= fifo_rd[DWIDTH-1:0];
      end

      if (state == ISSUE) begin
        tmo_cnt <= '0;
        got_rd  <= 1'b0;
        rd_cap  <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 32'd1;
        if (i_spi_rd_evt) begin
          rd_cap <= i_spi_rd_data;
          got_rd <= 1'b1;
        end
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      if (tmo_hit) begin
        timeout_flag_q <= 1'b1;
      end
    end
  end

endmodule
